noc_out_arbiter: RTL and testbench



---
 rtl/noc_pkg.sv | 31 +++
 rtl/noc_out_arbiter_if.sv | 43 ++++
 rtl/rr_pick3.sv | 52 +++++
 rtl/noc_out_arbiter.sv | 106 ++++++++++
 tb/tb_noc_out_arbiter.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/noc_pkg.sv
// Shared definitions for tree-NoC switch output ports.
//   - NUM_REQ       : number of input ports competing for one output link
//   - out_state_e   : state of the single-entry output register stage
//   - addr_msb/lsb  : position of the destination address field in a flit
//   - addr_in_range : inclusive unsigned destination range test
package noc_pkg;

    localparam int unsigned NUM_REQ = 3;

    typedef enum logic {
        StEmpty,
        StFull
    } out_state_e;

    // The destination address occupies the top AddrWidth bits of a flit.
    function automatic int unsigned addr_msb(input int unsigned data_width);
        return data_width - 1;
    endfunction

    function automatic int unsigned addr_lsb(input int unsigned data_width,
                                             input int unsigned addr_width);
        return data_width - addr_width;
    endfunction

    function automatic logic addr_in_range(input int unsigned addr,
                                           input int unsigned lo,
                                           input int unsigned hi);
        return (addr >= lo) && (addr <= hi);
    endfunction

endpackage

// File: rtl/noc_out_arbiter_if.sv
// Handshake bundle between three switch input ports and one output link.
//   i_data0/1/2, i_data_valid0/1/2 : flits offered by the requesters
//   o_data_ready0/1/2              : per-requester accept strobe
//   o_data, o_data_valid           : registered output flit toward downstream
//   i_data_ready                   : downstream accepts o_data
//   o_grant                        : one-hot index of the last loaded requester
// The slave modport is the arbiter's view; master is the surrounding switch.
interface noc_out_arbiter_if #(
    parameter int unsigned DataWidth = 34
);
    logic [DataWidth-1:0] i_data0;
    logic [DataWidth-1:0] i_data1;
    logic [DataWidth-1:0] i_data2;
    logic                 i_data_valid0;
    logic                 i_data_valid1;
    logic                 i_data_valid2;
    logic                 o_data_ready0;
    logic                 o_data_ready1;
    logic                 o_data_ready2;
    logic [DataWidth-1:0] o_data;
    logic                 o_data_valid;
    logic                 i_data_ready;
    logic [2:0]           o_grant;

    modport slave (
        input  i_data0, i_data1, i_data2,
        input  i_data_valid0, i_data_valid1, i_data_valid2,
        output o_data_ready0, o_data_ready1, o_data_ready2,
        output o_data, o_data_valid,
        input  i_data_ready,
        output o_grant
    );

    modport master (
        output i_data0, i_data1, i_data2,
        output i_data_valid0, i_data_valid1, i_data_valid2,
        input  o_data_ready0, o_data_ready1, o_data_ready2,
        input  o_data, o_data_valid,
        output i_data_ready,
        input  o_grant
    );

endinterface

// File: rtl/rr_pick3.sv
// Combinational three-way round-robin pick.
//   req   : request vector
//   ptr   : index granted last time (0..2); search starts just after it
//   grant : one-hot winner, all zero when nothing requests
//   index : binary winner index (meaningful only when grant is non-zero)
module rr_pick3
    import noc_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [1:0]         ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [1:0]         index
);

    logic [1:0] order [NUM_REQ];
    logic       found;

    always_comb begin
        // Search order (ptr+1)%3, (ptr+2)%3, ptr; the unused code 3 behaves like 2.
        case (ptr)
            2'd0: begin
                order[0] = 2'd1;
                order[1] = 2'd2;
                order[2] = 2'd0;
            end
            2'd1: begin
                order[0] = 2'd2;
                order[1] = 2'd0;
                order[2] = 2'd1;
            end
            default: begin
                order[0] = 2'd0;
                order[1] = 2'd1;
                order[2] = 2'd2;
            end
        endcase
    end

    always_comb begin
        grant = '0;
        index = 2'd0;
        found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req[order[i]]) begin
                found           = 1'b1;
                grant[order[i]] = 1'b1;
                index           = order[i];
            end
        end
    end

endmodule

// File: rtl/noc_out_arbiter.sv
// Round-robin arbiter sharing one outgoing switch link among three input ports.
// Only flits whose destination lies in [DestMin, DestMax] are forwarded; the
// winner is registered into a single-entry output stage (valid/ready).
//   i_clk, i_reset : clock and asynchronous active-high reset
//   bus (slave)    : requester flits/valids/readies, output flit, downstream ready, grant
module noc_out_arbiter
    import noc_pkg::*;
#(
    parameter int unsigned DataWidth  = 34,
    parameter int unsigned AddrWidth  = 2,
    parameter int unsigned DestMin    = 0,
    parameter int unsigned DestMax    = 0,
    parameter logic [2:0]  PortEnable = 3'b111
) (
    input  logic                i_clk,
    input  logic                i_reset,
    noc_out_arbiter_if.slave    bus
);

    localparam int unsigned AddrMsb = addr_msb(DataWidth);

    logic [DataWidth-1:0] data_in  [NUM_REQ];
    logic [NUM_REQ-1:0]   valid_in;
    logic [AddrWidth-1:0] dest     [NUM_REQ];
    logic [NUM_REQ-1:0]   req;

    logic [NUM_REQ-1:0]   pick_grant;
    logic [1:0]           pick_index;

    out_state_e           state_q, state_d;
    logic [DataWidth-1:0] data_q, data_d;
    logic [1:0]           ptr_q, ptr_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;

    logic                 can_load;
    logic                 load_ok;

    assign data_in[0] = bus.i_data0;
    assign data_in[1] = bus.i_data1;
    assign data_in[2] = bus.i_data2;
    assign valid_in   = {bus.i_data_valid2, bus.i_data_valid1, bus.i_data_valid0};

    always_comb begin
        for (int k = 0; k < NUM_REQ; k++) begin
            dest[k] = data_in[k][AddrMsb -: AddrWidth];
            req[k]  = valid_in[k] & PortEnable[k] &
                      addr_in_range(32'(dest[k]), DestMin, DestMax);
        end
    end

    rr_pick3 u_pick (
        .req   (req),
        .ptr   (ptr_q),
        .grant (pick_grant),
        .index (pick_index)
    );

    // The stage can take a flit when empty or when its current flit drains now.
    assign can_load = (state_q == StEmpty) | bus.i_data_ready;
    // Readies are forced low while reset is asserted even though the stage is empty.
    assign load_ok  = can_load & ~i_reset;

    assign bus.o_data_ready0 = load_ok & pick_grant[0];
    assign bus.o_data_ready1 = load_ok & pick_grant[1];
    assign bus.o_data_ready2 = load_ok & pick_grant[2];

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        if (can_load) begin
            if (|req) begin
                state_d = StFull;
                ptr_d   = pick_index;
                grant_d = pick_grant;
                for (int k = 0; k < NUM_REQ; k++) begin
                    if (pick_grant[k]) begin
                        data_d = data_in[k];
                    end
                end
            end else begin
                state_d = StEmpty;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= StEmpty;
            data_q  <= '0;
            ptr_q   <= 2'd2;  // port 0 gets first priority after reset
            grant_q <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
        end
    end

    assign bus.o_data       = data_q;
    assign bus.o_data_valid = (state_q == StFull);
    assign bus.o_grant      = grant_q;

endmodule

// File: tb/tb_noc_out_arbiter.sv
module tb_noc_out_arbiter;

    localparam int unsigned DW = 34;
    localparam int unsigned AW = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    noc_out_arbiter_if #(.DataWidth(DW)) bus_a ();
    noc_out_arbiter_if #(.DataWidth(DW)) bus_b ();

    noc_out_arbiter #(
        .DataWidth (DW), .AddrWidth (AW), .DestMin (1), .DestMax (1), .PortEnable (3'b111)
    ) u_dut_a (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus_a)
    );

    noc_out_arbiter #(
        .DataWidth (DW), .AddrWidth (AW), .DestMin (1), .DestMax (1), .PortEnable (3'b101)
    ) u_dut_b (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus_b)
    );

    // Both arbiters see identical upstream traffic.
    assign bus_b.i_data0       = bus_a.i_data0;
    assign bus_b.i_data1       = bus_a.i_data1;
    assign bus_b.i_data2       = bus_a.i_data2;
    assign bus_b.i_data_valid0 = bus_a.i_data_valid0;
    assign bus_b.i_data_valid1 = bus_a.i_data_valid1;
    assign bus_b.i_data_valid2 = bus_a.i_data_valid2;
    assign bus_b.i_data_ready  = bus_a.i_data_ready;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [DW-1:0] in_data [3];
    logic [2:0]    in_valid;
    logic          ds_ready;

    // Reference model: what each output stage holds, and the last winner.
    logic [DW-1:0] m_data  [2];
    logic          m_valid [2];
    int            m_ptr   [2];
    logic [2:0]    m_grant [2];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [2:0] en_of(input int m);
        return (m == 0) ? 3'b111 : 3'b101;
    endfunction

    function automatic logic [DW-1:0] mk_flit(input logic [1:0] d);
        return {d, 32'($urandom())};
    endfunction

    function automatic logic [2:0] model_req(input int m);
        logic [2:0] r;
        logic [2:0] en;
        logic [DW-1:0] f;
        en = en_of(m);
        for (int k = 0; k < 3; k++) begin
            f    = in_data[k];
            r[k] = in_valid[k] && en[k] && (f[DW-1 -: AW] == 2'd1);
        end
        return r;
    endfunction

    // Winner is the first requester found after the last winner, wrapping.
    function automatic int pick(input logic [2:0] r, input int p);
        for (int i = 1; i <= 3; i++) begin
            if (r[(p + i) % 3]) return (p + i) % 3;
        end
        return -1;
    endfunction

    function automatic logic [2:0] dut_rdy(input int m);
        if (m == 0) return {bus_a.o_data_ready2, bus_a.o_data_ready1, bus_a.o_data_ready0};
        return {bus_b.o_data_ready2, bus_b.o_data_ready1, bus_b.o_data_ready0};
    endfunction

    function automatic logic dut_valid(input int m);
        return (m == 0) ? bus_a.o_data_valid : bus_b.o_data_valid;
    endfunction

    function automatic logic [DW-1:0] dut_data(input int m);
        return (m == 0) ? bus_a.o_data : bus_b.o_data;
    endfunction

    function automatic logic [2:0] dut_grant(input int m);
        return (m == 0) ? bus_a.o_grant : bus_b.o_grant;
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            m_data[m]  = '0;
            m_valid[m] = 1'b0;
            m_ptr[m]   = 2;
            m_grant[m] = 3'b000;
        end
    endtask

    task automatic drive();
        bus_a.i_data0       = in_data[0];
        bus_a.i_data1       = in_data[1];
        bus_a.i_data2       = in_data[2];
        bus_a.i_data_valid0 = in_valid[0];
        bus_a.i_data_valid1 = in_valid[1];
        bus_a.i_data_valid2 = in_valid[2];
        bus_a.i_data_ready  = ds_ready;
    endtask

    task automatic set_all(input logic [2:0] v, input logic [1:0] d);
        in_valid = v;
        for (int k = 0; k < 3; k++) in_data[k] = mk_flit(d);
    endtask

    // Called at a falling edge: drive, check readies, advance one clock, check outputs.
    task automatic run_cycle();
        logic       can;
        logic [2:0] r;
        logic [2:0] e;
        int         g;
        drive();
        #1;
        for (int m = 0; m < 2; m++) begin
            can = !m_valid[m] || ds_ready;
            r   = model_req(m);
            g   = can ? pick(r, m_ptr[m]) : -1;
            e   = 3'b000;
            if (g >= 0) e[g] = 1'b1;
            check_eq($sformatf("ready%0d c%0d", m, cyc), 64'(dut_rdy(m)), 64'(e));
            if (can) begin
                if (g >= 0) begin
                    m_data[m]  = in_data[g];
                    m_valid[m] = 1'b1;
                    m_ptr[m]   = g;
                    m_grant[m] = e;
                end else begin
                    m_valid[m] = 1'b0;
                end
            end
        end
        @(posedge clk);
        #1;
        for (int m = 0; m < 2; m++) begin
            check_eq($sformatf("valid%0d c%0d", m, cyc), 64'(dut_valid(m)), 64'(m_valid[m]));
            check_eq($sformatf("data%0d c%0d", m, cyc), 64'(dut_data(m)), 64'(m_data[m]));
            check_eq($sformatf("grant%0d c%0d", m, cyc), 64'(dut_grant(m)), 64'(m_grant[m]));
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic check_reset_state(input string tag);
        for (int m = 0; m < 2; m++) begin
            check_eq($sformatf("%s valid%0d", tag, m), 64'(dut_valid(m)), 64'd0);
            check_eq($sformatf("%s data%0d", tag, m), 64'(dut_data(m)), 64'd0);
            check_eq($sformatf("%s grant%0d", tag, m), 64'(dut_grant(m)), 64'd0);
            check_eq($sformatf("%s ready%0d", tag, m), 64'(dut_rdy(m)), 64'd0);
        end
    endtask

    // Called at a falling edge; reset rises away from any clock edge.
    task automatic async_reset(input string tag);
        #2;
        rst = 1'b1;
        #1;
        check_reset_state(tag);
        model_reset();
        @(posedge clk);
        #1;
        check_reset_state({tag, " held"});
        @(negedge clk);
        rst = 1'b0;
    endtask

    logic [2:0] rr_a [3];
    logic [2:0] rr_b [2];
    logic [DW-1:0] bp_flit;

    initial begin
        rr_a[0] = 3'b001; rr_a[1] = 3'b010; rr_a[2] = 3'b100;
        rr_b[0] = 3'b001; rr_b[1] = 3'b100;
        bp_flit = 34'h1_0000_00AA;
        ds_ready = 1'b1;
        set_all(3'b111, 2'd1);
        drive();
        model_reset();
        #1;
        check_reset_state("init");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // All ports requesting: strict rotation, one flit per cycle.
        for (int i = 0; i < 6; i++) begin
            set_all(3'b111, 2'd1);
            run_cycle();
            check_eq($sformatf("rr_a %0d", i), 64'(bus_a.o_grant), 64'(rr_a[i % 3]));
            check_eq($sformatf("rr_b %0d", i), 64'(bus_b.o_grant), 64'(rr_b[i % 2]));
        end

        // Backpressure: a loaded flit stays put while downstream stalls.
        set_all(3'b001, 2'd1);
        in_data[0] = bp_flit;
        run_cycle();
        check_eq("bp load", 64'(bus_a.o_data), 64'(bp_flit));
        ds_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_all(3'b111, 2'd1);
            run_cycle();
        end
        check_eq("bp hold", 64'(bus_a.o_data), 64'(bp_flit));
        ds_ready = 1'b1;
        set_all(3'b111, 2'd1);
        run_cycle();
        check_eq("bp next a", 64'(bus_a.o_grant), 64'(3'b010));
        check_eq("bp next b", 64'(bus_b.o_grant), 64'(3'b100));

        // Address filter: port 1 is out of range, port 2 is in range.
        for (int i = 0; i < 3; i++) begin
            in_valid   = 3'b110;
            in_data[0] = mk_flit(2'd1);
            in_data[1] = mk_flit(2'd2);
            in_data[2] = mk_flit(2'd1);
            run_cycle();
            check_eq($sformatf("filter %0d", i), 64'(bus_a.o_grant), 64'(3'b100));
        end

        // Single requester back-to-back: drain and reload with no bubble.
        for (int i = 0; i < 3; i++) begin
            set_all(3'b010, 2'd1);
            run_cycle();
            check_eq($sformatf("b2b %0d", i), 64'(bus_a.o_data_valid), 64'd1);
        end

        // Reset with a held flit, then arbitration restarts at port 0.
        ds_ready = 1'b0;
        set_all(3'b111, 2'd1);
        run_cycle();
        check_eq("pre reset valid", 64'(bus_a.o_data_valid), 64'd1);
        async_reset("midrst");
        ds_ready = 1'b1;
        set_all(3'b111, 2'd1);
        run_cycle();
        check_eq("post reset grant", 64'(bus_a.o_grant), 64'(3'b001));

        // Randomized traffic with mixed destinations and downstream stalls.
        for (int i = 0; i < 400; i++) begin
            for (int k = 0; k < 3; k++) begin
                in_valid[k] = 1'($urandom_range(0, 1));
                in_data[k]  = mk_flit(($urandom_range(0, 1) == 0) ? 2'd1 : 2'($urandom_range(0, 3)));
            end
            ds_ready = ($urandom_range(0, 9) < 7);
            if (i == 200) begin
                in_valid = 3'b111;
                drive();
                async_reset("randrst");
            end else begin
                run_cycle();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
